alu_md: RTL
===========

ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal: 8, 16, 32, 64).
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH), width of shift amount.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port op_valid  input  1  operation request.
REQ-006 SHALL have port op_ready  output  1  block can accept an operation.
REQ-007 SHALL have port alu_ctrl  input  5  operation code (package enum).
REQ-008 SHALL have ports a, b  input  WIDTH  operands.
REQ-009 SHALL have port shamt  input  SHAMT_W  shift amount.
REQ-010 SHALL have port out  output  WIDTH  registered result.
REQ-011 SHALL have port zero  output  1  registered, high when out == 0.
REQ-012 SHALL have port res_valid  output  1  one-cycle pulse, out/zero updated.
REQ-013 SHALL have ports hi, lo  output  WIDTH  architectural HI/LO registers.
REQ-014 SHALL have port busy  output  1  multi-cycle operation in progress.

Function
REQ-015 Accept SHALL occur on a rising edge with op_valid && op_ready; op_ready = (state == IDLE), combinational from state only.
REQ-016 Single-cycle ops SHALL be NOP(0), ADD, SUB, AND, OR, NOR, XOR, SLT, SLTU, SLL, SRL, SRA, MFHI, MFLO; result registered into out, res_valid high the cycle after accept.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH, no overflow trap; SLT SHALL be signed and correct under subtraction overflow; SLTU unsigned.
REQ-018 Shifts SHALL operate on b by shamt; SRA sign-fills from b[WIDTH-1].
REQ-019 MULT/MULTU SHALL be iterative shift-add, one partial product per cycle; {hi,lo} = full 2*WIDTH-bit product, written WIDTH+1 cycles after accept.
REQ-020 DIV/DIVU SHALL be iterative restoring, one quotient bit per cycle; lo = quotient, hi = remainder, written WIDTH+1 cycles after accept.
REQ-021 Signed divide SHALL truncate toward zero; remainder takes dividend's sign; most-negative / -1 SHALL give lo = most-negative, hi = 0.
REQ-022 Divide by zero SHALL take full latency and give lo = all ones, hi = a.
REQ-023 Multi-cycle ops SHALL NOT write out; res_valid SHALL pulse with HI/LO write, out unchanged.
REQ-024 FSM states SHALL be IDLE, MUL, DIV, DONE: IDLE->MUL/DIV on accept of mult/div op; MUL/DIV->DONE when iteration count hits WIDTH-1; DONE->IDLE unconditionally.
REQ-025 busy SHALL be high in MUL, DIV, DONE; op_ready low in those states; op_valid ignored.
REQ-026 MFHI/MFLO accepted in IDLE SHALL return HI/LO values committed by any preceding completed operation (no hazard inside block).
REQ-027 Undefined alu_ctrl codes SHALL produce out = 0, zero = 1, res_valid pulse, as single-cycle.
REQ-028 Operands SHALL be captured at accept; later a/b changes SHALL NOT affect an in-flight operation.

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE, out = 0, zero = 1, res_valid = 0, hi = 0, lo = 0, busy = 0, iteration counter = 0.
REQ-030 Reset mid-operation SHALL abort it with no HI/LO write; op_ready high the first cycle after rst_n deasserts.

Configuration
REQ-031 Macro ALU_MD_DIV_EN SHALL compile in divide logic (DIV state, REQ-020..022).
REQ-032 Without ALU_MD_DIV_EN, DIV/DIVU SHALL behave as undefined codes (REQ-027), hi/lo unchanged, no DIV state.

Structure
REQ-033 Package alu_md_pkg SHALL hold the alu_ctrl enum (existing codes 0-9 keep values: NOP 0, ADD 1, SUB 2, AND 3, OR 4, NOR 5, SLT 6, SLL 7, SRL 8, SRA 9; new codes 10+), and the FSM state typedef.
REQ-034 Iterative multiply/divide datapath SHALL be sub-module alu_md_iter; single-cycle ops stay in alu_md.

Verification (WIDTH=32)
REQ-035 ADD 0x7FFFFFFF+1 -> out 0x80000000, res_valid next cycle; SUB 5-5 -> out 0, zero 1.
REQ-036 SLT a=0x80000000 b=1 -> out 1; SLTU same -> out 0; SRA b=0x80000000 shamt 4 -> 0xF8000000.
REQ-037 MULT a=-3 b=7 -> after 33 cycles hi=0xFFFFFFFF lo=0xFFFFFFEB; MULTU 0xFFFFFFFF^2 -> hi 0xFFFFFFFE lo 1; op_ready low throughout.
REQ-038 DIV -7/2 -> lo 0xFFFFFFFD hi 0xFFFFFFFF; DIVU 10/0 -> lo 0xFFFFFFFF hi 10; 0x80000000/-1 -> lo 0x80000000 hi 0.
REQ-039 rst_n pulsed mid-MULT (cycle 10) -> hi/lo 0, op_ready 1 after release, next ADD correct.
REQ-040 op_valid held high during busy with changing a/b -> single result for first op, no extra accepts; MFLO after completion returns new lo.

Source files
------------

// File: rtl/alu_md_pkg.sv
// Shared types for alu_md: operation codes and the multiply/divide sequencer states.
// Define ALU_MD_DIV_EN to build in the iterative divider and its DIV state.
package alu_md_pkg;

    typedef enum logic [4:0] {
        OP_NOP   = 5'd0,
        OP_ADD   = 5'd1,
        OP_SUB   = 5'd2,
        OP_AND   = 5'd3,
        OP_OR    = 5'd4,
        OP_NOR   = 5'd5,
        OP_SLT   = 5'd6,
        OP_SLL   = 5'd7,
        OP_SRL   = 5'd8,
        OP_SRA   = 5'd9,
        OP_XOR   = 5'd10,
        OP_SLTU  = 5'd11,
        OP_MFHI  = 5'd12,
        OP_MFLO  = 5'd13,
        OP_MULT  = 5'd14,
        OP_MULTU = 5'd15,
        OP_DIV   = 5'd16,
        OP_DIVU  = 5'd17
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
`ifdef ALU_MD_DIV_EN
        , DIV = 2'd3
`endif
    } state_e;

endpackage

// File: rtl/alu_md_iter.sv
// Iterative multiply/divide datapath: signs are stripped at start, one bit handled
// per step on magnitudes, and signs reapplied on the result. Divide under ALU_MD_DIV_EN.
module alu_md_iter
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d, a_q, a_d;
    logic               neg_q, neg_d, rneg_q, rneg_d, div_q, div_d, dz_q, dz_d;
    logic               sa, sb;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   q_mag, r_mag;
`ifdef ALU_MD_DIV_EN
    logic [WIDTH:0]     shifted, diff;
`endif

    assign sa = is_signed & a[WIDTH-1];
    assign sb = is_signed & b[WIDTH-1];

    always_comb begin
        acc_d   = acc_q;
        dvsr_d  = dvsr_q;
        a_d     = a_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div_d   = div_q;
        dz_d    = dz_q;
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? dvsr_q : {WIDTH{1'b0}})};
`ifdef ALU_MD_DIV_EN
        shifted = acc_q[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, dvsr_q};
`endif
        if (start) begin
            acc_d  = {{WIDTH{1'b0}}, (sa ? -a : a)};
            dvsr_d = sb ? -b : b;
            a_d    = a;
            neg_d  = sa ^ sb;
            rneg_d = sa;
            div_d  = is_div;
            dz_d   = is_div && (b == '0);
        end else if (step) begin
`ifdef ALU_MD_DIV_EN
            // Restoring step: low half shifts out dividend bits, shifts in quotient bits.
            if (div_q) begin
                if (!diff[WIDTH])
                    acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else
                    acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else
`endif
            begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        q_mag = acc_q[WIDTH-1:0];
        r_mag = acc_q[2*WIDTH-1:WIDTH];
        prod  = neg_q ? -acc_q : acc_q;
        if (div_q) begin
            lo_res = dz_q ? {WIDTH{1'b1}} : (neg_q ? -q_mag : q_mag);
            hi_res = dz_q ? a_q : (rneg_q ? -r_mag : r_mag);
        end else begin
            {hi_res, lo_res} = prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            dvsr_q <= '0;
            a_q    <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            div_q  <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            dvsr_q <= dvsr_d;
            a_q    <= a_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            div_q  <= div_d;
            dz_q   <= dz_d;
        end
    end

endmodule

// File: rtl/alu_md.sv
// ALU with registered single-cycle ops and an iterative HI/LO multiply (and divide
// when ALU_MD_DIV_EN is defined) sequenced by an IDLE/MUL/DIV/DONE FSM.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [4:0]         alu_ctrl,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   out,
    output logic               zero,
    output logic               res_valid,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_q, out_d, hi_q, hi_d, lo_q, lo_d, alu_res, iter_hi, iter_lo;
    logic               zero_q, zero_d, rv_q, rv_d;
    logic               accept, is_mul, is_div, is_multi, step, last;

    assign accept = op_valid && op_ready;
    assign is_mul = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_MULTU);
`ifdef ALU_MD_DIV_EN
    assign is_div = (alu_ctrl == OP_DIV) || (alu_ctrl == OP_DIVU);
    assign step   = (state_q == MUL) || (state_q == DIV);
`else
    assign is_div = 1'b0;
    assign step   = (state_q == MUL);
`endif
    assign is_multi = is_mul || is_div;
    assign last     = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && is_mul) state_d = MUL;
`ifdef ALU_MD_DIV_EN
                if (accept && is_div) state_d = DIV;
`endif
            end
            MUL:     if (last) state_d = DONE;
`ifdef ALU_MD_DIV_EN
            DIV:     if (last) state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
    end

    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOR:  alu_res = ~(a | b);
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  alu_res = b << shamt;
            OP_SRL:  alu_res = b >> shamt;
            OP_SRA:  alu_res = $signed(b) >>> shamt;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        cnt_d  = (step && !last) ? cnt_q + 1'b1 : '0;
        out_d  = out_q;
        zero_d = zero_q;
        rv_d   = 1'b0;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (accept && !is_multi) begin
            out_d  = alu_res;
            zero_d = (alu_res == '0);
            rv_d   = 1'b1;
        end
        // Multi-cycle results commit to HI/LO only; out keeps its last value.
        if (state_q == DONE) begin
            hi_d = iter_hi;
            lo_d = iter_lo;
            rv_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            out_q  <= '0;
            zero_q <= 1'b1;
            rv_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            zero_q <= zero_d;
            rv_q   <= rv_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    alu_md_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept && is_multi),
        .is_div    (is_div),
        .is_signed ((alu_ctrl == OP_MULT) || (alu_ctrl == OP_DIV)),
        .step      (step),
        .a         (a),
        .b         (b),
        .hi_res    (iter_hi),
        .lo_res    (iter_lo)
    );

    assign out       = out_q;
    assign zero      = zero_q;
    assign res_valid = rv_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule
